// File: rtl/pwr_cntr_writer.sv
// Power-counter write side: counts per-bit toggles of {S_OUT,Q} and periodically
// read-modify-writes them into memTrans. Optional macro PWR_CNTR_SAT_EN saturates the 32-bit update.
module pwr_cntr_writer #(
  parameter int unsigned NUM_SIG   = 5,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned THRESH    = 240,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              ENB,
  input  logic [3:0]        Q,
  input  logic              S_OUT,
  input  logic              FLUSH,
  output logic              BUSY,
  output logic [ADDR_W-1:0] DIR_MEM,
  output logic              LE,
  output logic [31:0]       DATO_OUT,
  input  logic [31:0]       DATO_IN
);

  localparam int unsigned IDX_W = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_SIG-1:0]  r_sample;
  logic                r_primed;
  logic [ACC_W-1:0]    r_acc [NUM_SIG];
  logic                r_busy;
  logic                r_le;
  logic [ADDR_W-1:0]   r_dir;
  logic [31:0]         r_dato;

  logic [NUM_SIG-1:0]  w_vec;
  logic                w_count;
  logic [NUM_SIG-1:0]  w_inc;
  logic                w_trig;
  logic [ACC_W-1:0]    w_acc_sel;
  logic [31:0]         w_sum;

  assign w_vec     = {S_OUT, Q};
  assign w_count   = ENB & r_primed;
  assign w_inc     = (w_vec ^ r_sample) & {NUM_SIG{w_count}};
  assign w_acc_sel = r_acc[r_idx];

  // Memory update: stored count plus the local snapshot
`ifdef PWR_CNTR_SAT_EN
  logic [32:0] w_sum_ext;
  assign w_sum_ext = {1'b0, DATO_IN} + 33'(w_acc_sel);
  assign w_sum     = w_sum_ext[32] ? 32'hFFFF_FFFF : w_sum_ext[31:0];
`else
  assign w_sum = DATO_IN + 32'(w_acc_sel);
`endif

  always_comb begin
    w_trig = 1'b0;
    for (int i = 0; i < NUM_SIG; i++) begin
      if (r_acc[i] >= ACC_W'(THRESH)) w_trig = 1'b1;
    end
  end

  // Sample register: the first enabled cycle only primes, never counts
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_sample <= '0;
      r_primed <= 1'b0;
    end else if (ENB) begin
      r_sample <= w_vec;
      r_primed <= 1'b1;
    end
  end

  // Saturating accumulators; the snapshotted one restarts from this cycle's toggle
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < NUM_SIG; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SIG; i++) begin
        if ((r_state == ST_READ) && (r_idx == IDX_W'(i))) begin
          r_acc[i] <= ACC_W'(w_inc[i]);
        end else if (w_inc[i] && (r_acc[i] != {ACC_W{1'b1}})) begin
          r_acc[i] <= r_acc[i] + ACC_W'(1);
        end
      end
    end
  end

  // Flush sequencer: READ/WRITE pair per signal, outputs registered
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_le    <= 1'b1;
      r_dir   <= ADDR_W'(BASE_ADDR);
      r_dato  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (FLUSH || w_trig) begin
            r_state <= ST_READ;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_le    <= 1'b1;
            r_dir   <= ADDR_W'(BASE_ADDR);
          end
        end
        ST_READ: begin
          r_state <= ST_WRITE;
          r_le    <= 1'b0;
          r_dato  <= w_sum;
        end
        ST_WRITE: begin
          r_le   <= 1'b1;
          r_dato <= '0;
          if (r_idx == IDX_W'(NUM_SIG - 1)) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_dir   <= ADDR_W'(BASE_ADDR);
          end else begin
            r_state <= ST_READ;
            r_idx   <= r_idx + IDX_W'(1);
            r_dir   <= r_dir + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_le    <= 1'b1;
          r_dato  <= '0;
        end
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign LE       = r_le;
  assign DIR_MEM  = r_dir;
  assign DATO_OUT = r_dato;

endmodule

// File: tb/tb_pwr_cntr_writer.sv
// Self-checking bench for pwr_cntr_writer: flush-sequence table, directed corner
// sequences and a randomized run against a toggle-count reference model.
module tb_pwr_cntr_writer;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        ENB;
  logic [3:0]  Q;
  logic        S_OUT;
  logic        FLUSH;
  logic        BUSY;
  logic [4:0]  DIR_MEM;
  logic        LE;
  logic [31:0] DATO_OUT;
  logic [31:0] DATO_IN;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [32];

  pwr_cntr_writer dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .Q(Q), .S_OUT(S_OUT), .FLUSH(FLUSH),
    .BUSY(BUSY), .DIR_MEM(DIR_MEM), .LE(LE), .DATO_OUT(DATO_OUT), .DATO_IN(DATO_IN)
  );

  always #5 CLK = ~CLK;

  // memTrans model: combinational read, write on the edge while LE=0
  assign DATO_IN = mem[DIR_MEM];
  always @(posedge CLK) begin
    if (RESET_L && !LE) mem[DIR_MEM] <= DATO_OUT;
  end

  // Reference: total counted toggles per monitored bit
  longint unsigned m_cnt [5];
  logic [4:0]      m_prev;
  bit              m_primed;
  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      m_primed = 1'b0;
      m_prev   = '0;
    end else if (ENB) begin
      if (m_primed)
        for (int i = 0; i < 5; i++)
          if ((({S_OUT, Q} >> i) & 5'd1) != ((m_prev >> i) & 5'd1)) m_cnt[i] = m_cnt[i] + 1;
      m_prev   = {S_OUT, Q};
      m_primed = 1'b1;
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] preset, input longint unsigned cnt);
    longint unsigned s;
    s = longint'(preset) + cnt;
`ifdef PWR_CNTR_SAT_EN
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
    return s[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_L = 1'b0; ENB = 1'b0; FLUSH = 1'b0; Q = 4'h0; S_OUT = 1'b0;
    step(); step();
    RESET_L = 1'b1;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 100) begin step(); n++; end
    if (BUSY) begin
      n_checks++; n_fail++;
      $display("FAIL %s: BUSY still high after 100 cycles", name);
    end
  endtask

  task automatic do_flush(input string name);
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    wait_idle(name);
  endtask

  typedef struct {
    logic        flush;
    logic        busy;
    logic        le;
    logic [4:0]  dir;
    logic [31:0] dato;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int c;
    int total;
    logic [31:0] pre [5];

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      tbl[2*k]   = '{flush: (k == 0), busy: 1'b1, le: 1'b1, dir: 5'(k), dato: 32'h0};
      tbl[2*k+1] = '{flush: 1'b0,     busy: 1'b1, le: 1'b0, dir: 5'(k), dato: 32'h0};
    end
    tbl[10] = '{flush: 1'b0, busy: 1'b0, le: 1'b1, dir: 5'd0, dato: 32'h0};
    tbl[11] = '{flush: 1'b0, busy: 1'b0, le: 1'b1, dir: 5'd0, dato: 32'h0};

    // Reset values
    do_reset();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_le", 32'(LE), 32'd1);
    chk("rst_dir", 32'(DIR_MEM), 32'd0);
    chk("rst_dato", DATO_OUT, 32'd0);

    // Constant inputs, full flush sequence cycle by cycle
    ENB = 1'b1; Q = 4'b1101; S_OUT = 1'b0;
    step(); step(); step();
    for (int r = 0; r < 12; r++) begin
      FLUSH = tbl[r].flush;
      step();
      chk($sformatf("tbl%0d_busy", r), 32'(BUSY), 32'(tbl[r].busy));
      chk($sformatf("tbl%0d_le", r), 32'(LE), 32'(tbl[r].le));
      chk($sformatf("tbl%0d_dir", r), 32'(DIR_MEM), 32'(tbl[r].dir));
      chk($sformatf("tbl%0d_dato", r), DATO_OUT, tbl[r].dato);
    end
    FLUSH = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("const_word%0d", i), mem[i], 32'd0);

    // Q alternating 0000/1111 for 20 counted cycles
    do_reset();
    ENB = 1'b1; Q = 4'h0; step();
    for (int k = 0; k < 20; k++) begin Q = ~Q; step(); end
    do_flush("alt_flush");
    for (int i = 0; i < 4; i++) chk($sformatf("alt_word%0d", i), mem[i], 32'd20);
    chk("alt_word4", mem[4], 32'd0);

    // Preset 100, five S_OUT toggles
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 32'd100;
    ENB = 1'b1; step();
    for (int k = 0; k < 5; k++) begin S_OUT = ~S_OUT; step(); end
    do_flush("sout_flush");
    for (int i = 0; i < 4; i++) chk($sformatf("sout_word%0d", i), mem[i], 32'd100);
    chk("sout_word4", mem[4], 32'd105);

    // Automatic flush on threshold, no toggles lost over repeated flushes
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 32'd0;
    ENB = 1'b1; step();
    c = 0; total = 0;
    while (!BUSY && c < 300) begin Q[0] = ~Q[0]; step(); c++; total++; end
    chk("auto_start_cycle", 32'(c), 32'd241);
    while (BUSY && c < 400) begin Q[0] = ~Q[0]; step(); c++; total++; end
    chk("auto_first_word0", mem[0], 32'd241);
    for (int k = 0; k < 700; k++) begin Q[0] = ~Q[0]; step(); total++; end
    ENB = 1'b0;
    wait_idle("auto_drain");
    do_flush("auto_final");
    chk("auto_total_word0", mem[0], 32'(total));
    chk("auto_model_word0", mem[0], exp_word(32'd0, m_cnt[0]));
    chk("auto_word1", mem[1], 32'd0);

    // 32-bit update boundary
    do_reset();
    mem[2] = 32'hFFFF_FFFE;
    ENB = 1'b1; step();
    for (int k = 0; k < 3; k++) begin Q[2] = ~Q[2]; step(); end
    do_flush("wrap_flush");
`ifdef PWR_CNTR_SAT_EN
    chk("wrap_word2", mem[2], 32'hFFFF_FFFF);
`else
    chk("wrap_word2", mem[2], 32'h0000_0001);
`endif

    // Reset during the third WRITE
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 32'd1000;
    ENB = 1'b1; step();
    for (int k = 0; k < 3; k++) begin Q = ~Q; S_OUT = ~S_OUT; step(); end
    FLUSH = 1'b1; step(); FLUSH = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_write2_le", 32'(LE), 32'd0);
    chk("mid_write2_dir", 32'(DIR_MEM), 32'd2);
    #2; RESET_L = 1'b0; #1;
    chk("mid_rst_le", 32'(LE), 32'd1);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    step();
    chk("mid_word0", mem[0], 32'd1003);
    chk("mid_word1", mem[1], 32'd1003);
    chk("mid_word2", mem[2], 32'd1000);
    #2; RESET_L = 1'b1; ENB = 1'b0; Q = 4'h0; S_OUT = 1'b0;
    step();
    ENB = 1'b1; Q = 4'hF; S_OUT = 1'b1;
    step(); step(); step();
    do_flush("mid_after_flush");
    chk("mid_prime_word3", mem[3], 32'd1000);
    chk("mid_prime_word4", mem[4], 32'd1000);
    chk("mid_prime_word0", mem[0], 32'd1003);

    // Randomized activity against the reference model
    do_reset();
    for (int i = 0; i < 5; i++) begin pre[i] = $urandom; mem[i] = pre[i]; end
    for (int k = 0; k < 1500; k++) begin
      ENB   = ($urandom_range(0, 9) < 7);
      Q     = 4'($urandom);
      S_OUT = 1'($urandom);
      FLUSH = ($urandom_range(0, 19) == 0);
      step();
    end
    ENB = 1'b0; FLUSH = 1'b0;
    wait_idle("rand_drain");
    do_flush("rand_final");
    for (int i = 0; i < 5; i++)
      chk($sformatf("rand_word%0d", i), mem[i], exp_word(pre[i], m_cnt[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
